// File: rtl/multicycle_control_fsm.sv
// Moore sequencing controller for the multicycle MIPS datapath: steps each
// instruction through fetch/decode/execute/memory/writeback and drives all selects.
module multicycle_control_fsm #(
    parameter int MEM_WAIT_EN = 1,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               memto_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         pc_src,
    output logic               pc_en,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMRD    = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWR    = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTE  = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_ADDIEXEC = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_ADDIWB   = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(11);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_next;
    logic               w_ready;
    logic               w_funct_ok;
    logic [2:0]         w_funct_alu;
    logic               w_pc_write;
    logic               w_branch;
    logic               w_mem_write_raw;
    logic               w_ir_write_raw;
    logic               w_reg_write_raw;
    logic               w_instr_done_raw;
    logic               w_illegal_raw;

    assign w_ready = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = ALU_ADD;
        case (funct)
            6'b100000: w_funct_alu = ALU_ADD;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_state_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_state_next = S_MEMADR;
                    OP_RTYPE:     w_state_next = w_funct_ok ? S_EXECUTE : S_FETCH;
                    OP_BEQ:       w_state_next = S_BRANCH;
                    OP_ADDI:      w_state_next = S_ADDIEXEC;
                    OP_J:         w_state_next = S_JUMP;
                    default:      w_state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)      w_state_next = S_MEMRD;
                else if (opcode == OP_SW) w_state_next = S_MEMWR;
                else                      w_state_next = S_FETCH;
            end
            S_MEMRD:    w_state_next = w_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    w_state_next = w_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE:  w_state_next = S_ALUWB;
            S_ADDIEXEC: w_state_next = S_ADDIWB;
            default:    w_state_next = S_FETCH;
        endcase
    end

    always_comb begin
        iord             = 1'b0;
        w_mem_write_raw  = 1'b0;
        w_ir_write_raw   = 1'b0;
        reg_dst          = 1'b0;
        memto_reg        = 1'b0;
        w_reg_write_raw  = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = 2'b00;
        alu_control      = 3'b000;
        pc_src           = 2'b00;
        w_pc_write       = 1'b0;
        w_branch         = 1'b0;
        w_instr_done_raw = 1'b0;
        w_illegal_raw    = 1'b0;
        case (r_state)
            S_FETCH: begin
                alu_src_b      = 2'b01;
                alu_control    = ALU_ADD;
                w_ir_write_raw = w_ready;
                w_pc_write     = w_ready;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
                // Anything that will not dispatch is flagged here, before any write.
                case (opcode)
                    OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_illegal_raw = 1'b0;
                    OP_RTYPE: w_illegal_raw = ~w_funct_ok;
                    default:  w_illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memto_reg        = 1'b1;
                w_reg_write_raw  = 1'b1;
                w_instr_done_raw = 1'b1;
            end
            S_MEMWR: begin
                iord             = 1'b1;
                w_mem_write_raw  = 1'b1;
                w_instr_done_raw = w_ready;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = w_funct_alu;
            end
            S_ALUWB: begin
                reg_dst          = 1'b1;
                w_reg_write_raw  = 1'b1;
                w_instr_done_raw = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_control      = ALU_SUB;
                pc_src           = 2'b01;
                w_branch         = 1'b1;
                w_instr_done_raw = 1'b1;
            end
            S_ADDIWB: begin
                w_reg_write_raw  = 1'b1;
                w_instr_done_raw = 1'b1;
            end
            S_JUMP: begin
                pc_src           = 2'b10;
                w_pc_write       = 1'b1;
                w_instr_done_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are suppressed during reset so an abandoned instruction leaves no trace.
    assign mem_write  = w_mem_write_raw  & ~reset;
    assign ir_write   = w_ir_write_raw   & ~reset;
    assign reg_write  = w_reg_write_raw  & ~reset;
    assign pc_en      = (w_pc_write | (w_branch & zero)) & ~reset;
    assign instr_done = w_instr_done_raw & ~reset;
    assign illegal_op = w_illegal_raw    & ~reset;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// cycle by cycle and compares state and the full control word.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;
    logic       pc_en, instr_done, illegal_op;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_WAIT_EN(1), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_src(pc_src), .pc_en(pc_en), .instr_done(instr_done),
        .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    // Control word: iord,mw,irw,rd,m2r,rw,sa,sb[2],ac[3],ps[2],pe,done,ill
    function automatic logic [16:0] cw(input logic io, input logic mw, input logic irw,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic [1:0] ps,
                                       input logic pe, input logic dn, input logic il);
        return {io, mw, irw, rd, m2r, rw, sa, sb, ac, ps, pe, dn, il};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, compare state and controls, then advance.
    task automatic cyc(input string tag, input logic mr, input logic z,
                       input logic [3:0] exp_state, input logic [16:0] exp_cw);
        logic [16:0] obs_cw;
        mem_ready = mr;
        zero      = z;
        #1;
        obs_cw = cw(iord, mem_write, ir_write, reg_dst, memto_reg, reg_write, alu_src_a,
                    alu_src_b, alu_control, pc_src, pc_en, instr_done, illegal_op);
        check_val({tag, ".state"}, 32'(state_dbg), 32'(exp_state));
        check_val({tag, ".ctl"}, 32'(obs_cw), 32'(exp_cw));
        $display("cycle %-12s state=%0d ctl=0x%05h", tag, state_dbg, obs_cw);
        @(posedge clk);
        #1;
    endtask

    localparam logic [16:0] CW_FETCH  = 17'b0_0_1_0_0_0_0_01_010_00_1_0_0;
    localparam logic [16:0] CW_FSTALL = 17'b0_0_0_0_0_0_0_01_010_00_0_0_0;
    localparam logic [16:0] CW_DECODE = 17'b0_0_0_0_0_0_0_11_010_00_0_0_0;
    localparam logic [16:0] CW_DILL   = 17'b0_0_0_0_0_0_0_11_010_00_0_0_1;
    localparam logic [16:0] CW_MEMADR = 17'b0_0_0_0_0_0_1_10_010_00_0_0_0;
    localparam logic [16:0] CW_MEMRD  = 17'b1_0_0_0_0_0_0_00_000_00_0_0_0;
    localparam logic [16:0] CW_MEMWB  = 17'b0_0_0_0_1_1_0_00_000_00_0_1_0;
    localparam logic [16:0] CW_MWWAIT = 17'b1_1_0_0_0_0_0_00_000_00_0_0_0;
    localparam logic [16:0] CW_MWDONE = 17'b1_1_0_0_0_0_0_00_000_00_0_1_0;
    localparam logic [16:0] CW_EXSLT  = 17'b0_0_0_0_0_0_1_00_111_00_0_0_0;
    localparam logic [16:0] CW_ALUWB  = 17'b0_0_0_1_0_1_0_00_000_00_0_1_0;
    localparam logic [16:0] CW_BRT    = 17'b0_0_0_0_0_0_1_00_110_01_1_1_0;
    localparam logic [16:0] CW_BRN    = 17'b0_0_0_0_0_0_1_00_110_01_0_1_0;
    localparam logic [16:0] CW_ADDIWB = 17'b0_0_0_0_0_1_0_00_000_00_0_1_0;
    localparam logic [16:0] CW_JUMP   = 17'b0_0_0_0_0_0_0_00_000_10_1_1_0;

    initial begin
        reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Get to MEMWR with a stall, then reset for 3 cycles there.
        opcode = 6'b101011;
        cyc("rst.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("rst.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("rst.memadr", 1'b1, 1'b0, 4'd2, CW_MEMADR);
        mem_ready = 1'b0;
        #1;
        check_val("rst.pre_mw", 32'(mem_write), 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("rst.mw%0d", i), 32'(mem_write), 32'd0);
            check_val($sformatf("rst.done%0d", i), 32'(instr_done), 32'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        opcode = 6'b100011;

        // lw, mem_ready tied high: 5 cycles.
        cyc("lw.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("lw.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("lw.memadr", 1'b1, 1'b0, 4'd2, CW_MEMADR);
        cyc("lw.memrd", 1'b1, 1'b0, 4'd3, CW_MEMRD);
        cyc("lw.memwb", 1'b1, 1'b0, 4'd4, CW_MEMWB);

        // sw with three wait cycles in MEMWR: 7 cycles.
        opcode = 6'b101011;
        cyc("sw.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("sw.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("sw.memadr", 1'b1, 1'b0, 4'd2, CW_MEMADR);
        cyc("sw.wait0", 1'b0, 1'b0, 4'd5, CW_MWWAIT);
        cyc("sw.wait1", 1'b0, 1'b0, 4'd5, CW_MWWAIT);
        cyc("sw.wait2", 1'b0, 1'b0, 4'd5, CW_MWWAIT);
        cyc("sw.ready", 1'b1, 1'b0, 4'd5, CW_MWDONE);

        // R-type slt.
        opcode = 6'b000000; funct = 6'b101010;
        cyc("slt.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("slt.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("slt.exec", 1'b1, 1'b0, 4'd6, CW_EXSLT);
        cyc("slt.aluwb", 1'b1, 1'b0, 4'd7, CW_ALUWB);

        // R-type with unsupported funct.
        funct = 6'b000000;
        cyc("sll.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("sll.decode", 1'b1, 1'b0, 4'd1, CW_DILL);

        // beq taken then not taken.
        opcode = 6'b000100;
        cyc("beqt.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("beqt.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("beqt.branch", 1'b1, 1'b1, 4'd8, CW_BRT);
        cyc("beqn.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("beqn.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("beqn.branch", 1'b1, 1'b0, 4'd8, CW_BRN);

        // addi with one stalled fetch cycle.
        opcode = 6'b001000;
        cyc("addi.fstall", 1'b0, 1'b0, 4'd0, CW_FSTALL);
        cyc("addi.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("addi.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("addi.exec", 1'b1, 1'b0, 4'd9, CW_MEMADR);
        cyc("addi.wb", 1'b1, 1'b0, 4'd10, CW_ADDIWB);

        // j, then an illegal opcode.
        opcode = 6'b000010;
        cyc("j.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("j.decode", 1'b1, 1'b0, 4'd1, CW_DECODE);
        cyc("j.jump", 1'b1, 1'b0, 4'd11, CW_JUMP);
        opcode = 6'b111111;
        cyc("bad.fetch", 1'b1, 1'b0, 4'd0, CW_FETCH);
        cyc("bad.decode", 1'b1, 1'b0, 4'd1, CW_DILL);
        mem_ready = 1'b0;
        #1;
        check_val("bad.return", 32'(state_dbg), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle MIPS datapath: a single shared ALU, one unified instruction/data memory, and registered IR, A, B, ALUOut and Data.
- A Moore FSM steps each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux select and write enable.
- Integrates the ALU function decode and a memory ready handshake.
- Supports lw, sw, beq, addi, j and R-type add/sub/and/or/slt.

Parameters:
MEM_WAIT_EN, 1, 1 = stall on mem_ready; 0 = mem_ready ignored (treated as 1)
STATE_W, 4, width of the state register / state_dbg port

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag (current cycle)
mem_ready  input  1  memory access completes this cycle
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  output  1  memory write strobe
ir_write  output  1  IR load enable
reg_dst  output  1  register destination: 0 = rt, 1 = rd
memto_reg  output  1  writeback data: 0 = ALUOut, 1 = Data
reg_write  output  1  register file write enable
alu_src_a  output  1  ALU A input: 0 = PC, 1 = A
alu_src_b  output  2  ALU B input: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
alu_control  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
pc_en  output  1  PC load = pc_write | (branch & zero)
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
illegal_op  output  1  one-cycle pulse on an unsupported opcode/funct
state_dbg  output  STATE_W  current state encoding

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Encodings 12-15 are illegal and go to FETCH.
- Outputs are combinational from state (plus mem_ready, zero, funct). Every output not listed for a state is 0; no x values are driven.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_control=add, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Holds in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_b=11, alu_control=add (precomputes the branch target).
  - Next state by opcode: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; addi -> ADDIEXEC; j -> JUMP.
  - R-type with a funct outside {100000, 100010, 100100, 100101, 101010}, or any other opcode: illegal_op=1, next state FETCH, no writes.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, memto_reg=1, reg_write=1, instr_done=1. Then FETCH.
- MEMWR: iord=1, mem_write=1, held stable while waiting.
  - On mem_ready: instr_done=1, then FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_control from funct. Then ALUWB.
- ALUWB: reg_dst=1, reg_write=1, instr_done=1. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, branch=1, instr_done=1. Then FETCH.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, add. Then ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1, instr_done=1. Then FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1. Then FETCH.
- Latency with no memory wait:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds 1 cycle.
- Reset:
  - While reset=1, mem_write, ir_write, reg_write, pc_en, instr_done and illegal_op are forced 0, regardless of state.
  - The state register takes FETCH at the next edge.
  - Reset asserted mid-instruction (including a MEMWR stall) abandons the instruction; no partial writeback occurs.
  - After reset deasserts, the first cycle is FETCH.
- With MEM_WAIT_EN=0, mem_ready is ignored and no state ever stalls.
- mem_ready high outside FETCH/MEMRD/MEMWR has no effect.

Test Plan:
- Reset held 3 cycles in MEMWR with mem_ready=0 -> mem_write=0 throughout reset; state_dbg=0 on the first cycle after release.
- lw (opcode 100011), mem_ready tied 1 -> states 0,1,2,3,4; reg_write=1 and memto_reg=1 only in cycle 5; instr_done pulses once.
- sw (101011), mem_ready low 3 cycles in MEMWR -> mem_write=1 and iord=1 held 4 cycles; instr_done only in the mem_ready cycle; total 7 cycles.
- R-type funct 101010 -> EXECUTE with alu_control=111, then ALUWB with reg_dst=1. funct 000000 -> illegal_op pulse in DECODE, next state FETCH, no reg_write.
- beq with zero=1 -> pc_en=1 and pc_src=01 in BRANCH. With zero=0 -> pc_en=0; both cases return to FETCH after 3 cycles.
- j (000010) -> pc_src=10 and pc_en=1 in cycle 3; opcode 111111 -> illegal_op=1 and return to FETCH.
